adc_boxcar_decimator: RTL and testbench

- Accumulate-and-dump decimator between the ADC host (16-bit samples + one-cycle `newdata` strobe) and the capture SRAM write path.
- Averages 2^k consecutive samples, with k selectable at run time, and emits one rounded 16-bit sample plus a one-cycle valid strobe per block.
- Lowers the effective sample rate so the 64k-word SRAM covers longer capture windows, and improves SNR for lock-in measurements.

---
 rtl/adc_boxcar_decimator.sv | 114 +++++++++++
 tb/tb_adc_boxcar_decimator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_boxcar_decimator.sv
// Boxcar (accumulate-and-dump) decimator for the ADC capture path.
// Averages 2^k samples (k = dec_sel, clamped to MAX_LOG2) and emits one
// rounded DW-bit sample with a one-cycle strobe per completed block.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   en             : capture enable (low = idle, partial block flushed)
//   dec_sel        : decimation exponent k
//   din, din_valid : ADC sample and its one-cycle strobe
//   dout, dout_valid : averaged sample and its one-cycle strobe
//   blk_count      : blocks emitted since en rose (wraps)
//   busy           : a block is partially accumulated
module adc_boxcar_decimator #(
    parameter int DW         = 16,
    parameter int MAX_LOG2   = 7,
    parameter int SKIP_FIRST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [2:0]    dec_sel,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic [15:0]   blk_count,
    output logic          busy
);

    localparam int AW = DW + MAX_LOG2;
    localparam int CW = MAX_LOG2 + 1;
    localparam int KW = (MAX_LOG2 > 1) ? $clog2(MAX_LOG2 + 1) : 1;
    localparam int SW = (SKIP_FIRST > 0) ? $clog2(SKIP_FIRST + 1) : 1;
    localparam logic [SW-1:0] SKIP_INIT = SW'(SKIP_FIRST);

    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k_lat;
    logic [SW-1:0] skip;
    logic          en_d;

    logic          start;
    logic          rise;
    logic          done;
    logic [KW-1:0] k_sel;
    logic [KW-1:0] k_use;
    logic [CW-1:0] cnt_nxt;
    logic [AW-1:0] total;
    logic [AW:0]   rnd;
    logic [AW:0]   rounded;

    always_comb begin
        k_sel   = (int'(dec_sel) > MAX_LOG2) ? KW'(MAX_LOG2) : KW'(dec_sel);
        start   = (cnt == '0);
        rise    = en && !en_d;
        // The block length is fixed by dec_sel at the first sample only.
        k_use   = start ? k_sel : k_lat;
        cnt_nxt = cnt + 1'b1;
        total   = (start ? '0 : acc) + AW'(din);
        done    = (cnt_nxt == (CW'(1) << k_use));
        rnd     = '0;
        if (k_use != '0) begin
            rnd = (AW + 1)'(1) << (k_use - 1'b1);
        end
        // Max sum plus half-LSB stays below 2^AW, so the result fits DW.
        rounded = ({1'b0, total} + rnd) >> k_use;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            k_lat      <= '0;
            skip       <= SKIP_INIT;
            en_d       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            blk_count  <= '0;
            busy       <= 1'b0;
        end else begin
            en_d       <= en;
            dout_valid <= 1'b0;
            if (rise) begin
                blk_count <= '0;
            end
            if (!en) begin
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b0;
                skip <= SKIP_INIT;
            end else if (din_valid) begin
                if (skip != '0) begin
                    skip <= skip - 1'b1;
                end else begin
                    if (start) begin
                        k_lat <= k_sel;
                    end
                    if (done) begin
                        acc        <= '0;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        dout       <= rounded[DW-1:0];
                        dout_valid <= 1'b1;
                        blk_count  <= rise ? 16'd1 : blk_count + 16'd1;
                    end else begin
                        acc  <= total;
                        cnt  <= cnt_nxt;
                        busy <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_boxcar_decimator.sv
// Self-checking bench for adc_boxcar_decimator.
// A sample-list model pushes expected averages; a monitor pops them.
module tb_adc_boxcar_decimator;

    localparam int SKIP = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  dec_sel;
    logic [15:0] din;
    logic        din_valid;
    logic [15:0] dout;
    logic        dout_valid;
    logic [15:0] blk_count;
    logic        busy;

    adc_boxcar_decimator #(
        .DW(16),
        .MAX_LOG2(7),
        .SKIP_FIRST(SKIP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .dec_sel(dec_sel),
        .din(din),
        .din_valid(din_valid),
        .dout(dout),
        .dout_valid(dout_valid),
        .blk_count(blk_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] exp_q[$];
    int          exp_cyc_q[$];
    int          m_samp[$];
    int          m_skip;
    int          m_k;
    bit          m_en_d;

    logic [15:0] mon_e;
    int          mon_c;

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dout: got dout=%h at cycle %0d, required no output",
                         dout, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                if (dout !== mon_e || cyc != mon_c) begin
                    errors++;
                    $display("FAIL dout: got %h at cycle %0d, required %h at cycle %0d",
                             dout, cyc, mon_e, mon_c);
                end
            end
        end
    end

    task automatic step(input bit e, input logic [2:0] s,
                        input logic [15:0] d, input bit v);
        int sum;
        int n;
        @(negedge clk);
        en        = e;
        dec_sel   = s;
        din       = d;
        din_valid = v;
        m_en_d    = e;
        if (!e) begin
            m_samp.delete();
            m_skip = SKIP;
        end else if (v) begin
            if (m_skip > 0) begin
                m_skip--;
            end else begin
                if (m_samp.size() == 0) m_k = (int'(s) > 7) ? 7 : int'(s);
                m_samp.push_back(int'(d));
                n = 1 << m_k;
                if (m_samp.size() == n) begin
                    sum = 0;
                    foreach (m_samp[i]) sum += m_samp[i];
                    exp_q.push_back(16'((sum + n / 2) / n));
                    exp_cyc_q.push_back(cyc + 1);
                    m_samp.delete();
                end
            end
        end
    endtask

    task automatic idle(input bit e, input int n);
        for (int i = 0; i < n; i++) step(e, 3'd0, 16'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        en        = 1'b0;
        din_valid = 1'b0;
        m_samp.delete();
        m_skip = SKIP;
        m_en_d = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 4;
        if (dout !== 16'h0) begin
            errors++; $display("FAIL rst_dout: got %h, required 0000", dout);
        end
        if (dout_valid !== 1'b0) begin
            errors++; $display("FAIL rst_dout_valid: got %b, required 0", dout_valid);
        end
        if (blk_count !== 16'h0) begin
            errors++; $display("FAIL rst_blk_count: got %h, required 0000", blk_count);
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_passthrough();
        step(1, 3'd0, 16'h0100, 1);
        idle(1, 1);
        step(1, 3'd0, 16'h0200, 1);
        idle(1, 1);
        step(1, 3'd0, 16'h0300, 1);
        idle(1, 2);
        vectors++;
        if (blk_count !== 16'd2) begin
            errors++; $display("FAIL pass_blk_count: got %0d, required 2", blk_count);
        end
        idle(0, 1);
        step(1, 3'd0, 16'h1111, 1);
        for (int i = 0; i < 20; i++) step(1, 3'd0, 16'($urandom), 1);
        idle(1, 2);
        vectors++;
        if (blk_count !== 16'd20) begin
            errors++; $display("FAIL k0_blk_count: got %0d, required 20", blk_count);
        end
    endtask

    task automatic test_average();
        idle(0, 1);
        step(1, 3'd2, 16'h5555, 1);
        step(1, 3'd2, 16'd1, 1);
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL avg_busy_first: got %b, required 1", busy);
        end
        step(1, 3'd2, 16'd2, 1);
        step(1, 3'd2, 16'd3, 1);
        step(1, 3'd2, 16'd4, 1);
        @(posedge clk); #1;
        vectors += 3;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL avg_busy_end: got %b, required 0", busy);
        end
        if (dout !== 16'h0003) begin
            errors++; $display("FAIL avg_dout: got %h, required 0003", dout);
        end
        if (blk_count !== 16'd1) begin
            errors++; $display("FAIL avg_blk_count: got %0d, required 1", blk_count);
        end
        idle(1, 2);
    endtask

    task automatic test_back_to_back();
        idle(0, 1);
        step(1, 3'd7, 16'hFFFF, 1);
        for (int i = 0; i < 256; i++) step(1, 3'd7, 16'hFFFF, 1);
        for (int i = 0; i < 128; i++) step(1, 3'd7, 16'($urandom), 1);
        idle(1, 3);
        vectors += 2;
        if (blk_count !== 16'd3) begin
            errors++; $display("FAIL b2b_blk_count: got %0d, required 3", blk_count);
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL b2b_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_en_drop();
        idle(0, 1);
        step(1, 3'd3, 16'hAAAA, 1);
        for (int i = 0; i < 5; i++) step(1, 3'd3, 16'($urandom), 1);
        step(0, 3'd3, 16'h7777, 1);
        step(0, 3'd3, 16'h7777, 1);
        step(1, 3'd3, 16'hBEEF, 1);
        for (int i = 0; i < 8; i++) step(1, 3'd3, 16'h0010, 1);
        idle(1, 2);
        vectors += 2;
        if (dout !== 16'h0010) begin
            errors++; $display("FAIL drop_dout: got %h, required 0010", dout);
        end
        if (blk_count !== 16'd1) begin
            errors++; $display("FAIL drop_blk_count: got %0d, required 1", blk_count);
        end
    endtask

    task automatic test_sel_change();
        idle(0, 1);
        step(1, 3'd1, 16'h9999, 1);
        step(1, 3'd1, 16'd100, 1);
        step(1, 3'd4, 16'd301, 1);
        for (int i = 0; i < 16; i++)
            step(1, (i < 4) ? 3'd4 : 3'd0, 16'($urandom), 1);
        idle(1, 2);
        vectors++;
        if (blk_count !== 16'd2) begin
            errors++; $display("FAIL sel_blk_count: got %0d, required 2", blk_count);
        end
    endtask

    task automatic test_reset_mid();
        idle(0, 1);
        step(1, 3'd2, 16'h1234, 1);
        for (int i = 0; i < 3; i++) step(1, 3'd2, 16'hF000, 1);
        test_reset();
        idle(0, 1);
        step(1, 3'd2, 16'h4321, 1);
        for (int i = 0; i < 4; i++) step(1, 3'd2, 16'($urandom), 1);
        idle(1, 2);
        vectors++;
        if (blk_count !== 16'd1) begin
            errors++; $display("FAIL rmid_blk_count: got %0d, required 1", blk_count);
        end
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        dec_sel   = 3'd0;
        din       = 16'd0;
        din_valid = 1'b0;
        m_skip    = SKIP;
        m_k       = 0;
        m_en_d    = 1'b0;
        test_reset();
        test_passthrough();
        test_average();
        test_back_to_back();
        test_en_drop();
        test_sel_change();
        test_reset_mid();
        idle(0, 3);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
